gpio_irq: RTL and testbench
===========================

Name: gpio_irq

Overview:
- Per-pin input conditioning and interrupt controller for the 8-bit GPIO port.
- Consumes the 8 raw pin inputs delivered by the GPIO block's input buffers.
- Synchronises and debounces each pin, detects the selected edge, latches per-pin interrupt flags and drives one interrupt line to the CPU.
- Sits on the CPU data bus beside the GPIO block and uses the same addr/din/dout/wr_en/rd_en register interface.

Parameters:
- ADDR_LSB, 0: lowest addr bit used for register decode.
- OPT_MEM_ADDR_BITS, 1: local address is addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB], giving 4 registers.
- DEBOUNCE_BITS, 4: width of the per-pin debounce counter, minimum 1. DB_MAX = 2^DEBOUNCE_BITS - 1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- addr  input  8  CPU register address.
- din  input  8  CPU write data.
- dout  output  8  CPU read data, registered.
- wr_en  input  1  write strobe, one cycle.
- rd_en  input  1  read strobe, one cycle.
- pin_in  input  8  raw pin levels from the GPIO input buffers, asynchronous to clk.
- irq  output  1  level interrupt to the CPU.

Behaviour:
- Reset (asynchronous, reset_n=0): all registers, synchronisers, debounced levels and counters go to 0; dout=8'h00, irq=0.
- Register map (local address):
  - 00 IE: interrupt enable per pin, R/W.
  - 01 EDGE: per-pin edge select, 1=rising, 0=falling, R/W.
  - 10 IFLAG: read returns flags; write is write-1-to-clear.
  - 11 LEVEL: debounced pin levels, read-only; writes ignored.
- Bus timing:
  - wr_en has priority over rd_en when both are high.
  - Write takes effect at the clk edge where wr_en=1.
  - Read: dout is loaded at the edge where rd_en=1 (valid the following cycle, 1-cycle latency).
  - dout holds its value when rd_en=0 or during a write.
- Synchroniser: per pin, two flops (s1, s2); s2 lags pin_in by 2 edges.
- Debounce: per pin, counter cnt[DEBOUNCE_BITS-1:0] and debounced level deb. At each edge:
  - if s2==deb: cnt<=0;
  - else if cnt==DB_MAX: deb<=s2, cnt<=0, edge event fires;
  - else cnt<=cnt+1.
- Debounce timing:
  - A level must persist on s2 for DB_MAX+1 consecutive edges before deb changes.
  - Any bounce back resets cnt.
  - Step on pin_in before edge 1: deb updates at edge DB_MAX+3 (edge 18 for the default).
- Edge event: IFLAG[i] is set at the same edge deb[i] updates, if the new deb[i] matches EDGE[i] (0->1 with EDGE=1, or 1->0 with EDGE=0). Flags set regardless of IE.
- Simultaneous flag set and W1C clear of the same bit in one cycle: set wins, flag stays 1.
- irq = |(IFLAG & IE), combinational from registers.
  - Enabling IE on an already-set flag asserts irq on the next cycle.
  - irq stays high until all enabled flags are cleared.
- Changing EDGE does not create an event and does not alter existing flags.
- Pins already high at reset: deb rises DB_MAX+3 edges after reset release, setting IFLAG for pins with EDGE=1. Software clears flags after configuring.
- A reset asserted mid-debounce discards the count with no event.

Test Plan:
1. Reset, then read all 4 addresses -> dout 8'h00 each, irq=0. Write 8'hA5 to addr 0 and read back -> 8'hA5. Write 8'hFF to addr 3, then read addr 3 -> 8'h00 with pins low.
2. DEBOUNCE_BITS=2, EDGE=8'h01, IE=8'h01; pin_in[0] steps 0->1 before edge 1 -> IFLAG=8'h01 and irq=1 after edge 6, not before. LEVEL reads 8'h01.
3. DEBOUNCE_BITS=2; pin_in[1] high for 3 cycles then low -> LEVEL stays 8'h00 and IFLAG stays 8'h00. Same pulse held 6 cycles -> LEVEL bit 1 set.
4. EDGE=8'h00, pin_in[2] 1->0 after settling high -> IFLAG=8'h04. With IE=8'h00, irq=0; write IE=8'h04 -> irq=1 next cycle. Write 8'h04 to addr 2 -> IFLAG=8'h00, irq=0.
5. Arrange the pin_in[3] rising event to land at the same edge as a W1C write of 8'h08 -> IFLAG bit 3 remains 1.
6. wr_en and rd_en high together on addr 0 -> IE updated, dout unchanged. Assert reset_n=0 mid-debounce -> all registers 0 immediately, no flag after release until a full DB_MAX+3-edge window elapses.

Source files
------------

// File: rtl/gpio_irq_if.sv
// CPU register bus shared by the GPIO block and its interrupt controller.
interface gpio_irq_if;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wr_en;
  logic       rd_en;

  modport master (output addr, din, wr_en, rd_en, input dout);
  modport slave  (input addr, din, wr_en, rd_en, output dout);
endinterface

// File: rtl/gpio_irq.sv
// GPIO input conditioning: per-pin 2-flop sync + debounce, edge-selectable
// interrupt flags with W1C clear, and a single level irq to the CPU.
module gpio_irq_pin #(
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic deb,
  output logic lvl,
  output logic fire
);
  localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;

  logic [1:0]               sync;
  logic [DEBOUNCE_BITS-1:0] cnt;

  assign lvl  = sync[1];
  // fire marks the edge at which deb takes the value of lvl
  assign fire = (lvl != deb) && (cnt == DB_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      if (lvl == deb) begin
        cnt <= '0;
      end else if (cnt == DB_MAX) begin
        deb <= lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module gpio_irq #(
  parameter int ADDR_LSB          = 0,
  parameter int OPT_MEM_ADDR_BITS = 1,
  parameter int DEBOUNCE_BITS     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_irq_if.slave        bus,
  input  logic [7:0]       pin_in,
  output logic             irq
);
  localparam int NUM_LANES = 8;
  localparam int AW        = OPT_MEM_ADDR_BITS + 1;

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic [AW-1:0] la;
    logic [7:0]    data;
  } bus_req_t;

  bus_req_t req;
  assign req.wr   = bus.wr_en;
  assign req.rd   = bus.rd_en;
  assign req.la   = bus.addr[ADDR_LSB +: AW];
  assign req.data = bus.din;

  logic unused_addr;
  assign unused_addr = ^bus.addr;

  logic [NUM_LANES-1:0] deb, lvl, fire;
  logic [NUM_LANES-1:0] ie, edge_sel, iflag;
  logic [NUM_LANES-1:0] set, clr;
  logic [7:0]           dout_q;

  gpio_irq_pin #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_pin [NUM_LANES-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (pin_in),
    .deb     (deb),
    .lvl     (lvl),
    .fire    (fire)
  );

  // new debounced level is lvl on a firing pin; flag when it matches the edge select
  assign set = fire & ~(lvl ^ edge_sel);
  assign clr = (req.wr && req.la == AW'(2)) ? req.data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie       <= '0;
      edge_sel <= '0;
      iflag    <= '0;
    end else begin
      if (req.wr && req.la == AW'(0)) ie       <= req.data;
      if (req.wr && req.la == AW'(1)) edge_sel <= req.data;
      iflag <= (iflag & ~clr) | set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= 8'h00;
    end else if (!req.wr && req.rd) begin
      case (req.la)
        AW'(0):  dout_q <= ie;
        AW'(1):  dout_q <= edge_sel;
        AW'(2):  dout_q <= iflag;
        AW'(3):  dout_q <= deb;
        default: dout_q <= 8'h00;
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign irq      = |(iflag & ie);
endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq with a sliding-window reference model checked every cycle.
module tb_gpio_irq;
  localparam int DB  = 2;
  localparam int DBM = (1 << DB) - 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pin_in = 8'h00;
  logic       irq;
  int         n_tests = 0;
  int         n_fail  = 0;

  gpio_irq_if bif ();

  gpio_irq #(.ADDR_LSB(0), .OPT_MEM_ADDR_BITS(1), .DEBOUNCE_BITS(DB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif),
    .pin_in  (pin_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference: deb flips when the last DBM+1 synchronised samples all disagree with it.
  logic [7:0]           m_p1, m_p2, m_deb, m_ie, m_edg, m_flag, m_dout;
  logic [DBM:0][7:0]    m_hist, m_nw;
  logic [7:0]           m_tog, m_ndeb, m_set, m_clr;
  logic [1:0]           m_la;

  always_comb begin
    m_nw  = {m_hist[DBM-1:0], m_p2};
    m_tog = 8'hFF;
    for (int k = 0; k <= DBM; k++)
      for (int i = 0; i < 8; i++)
        if (m_nw[k][i] == m_deb[i]) m_tog[i] = 1'b0;
    m_ndeb = m_deb ^ m_tog;
    m_set  = m_tog & ~(m_ndeb ^ m_edg);
    m_la   = bif.addr[1:0];
    m_clr  = (bif.wr_en && m_la == 2'd2) ? bif.din : 8'h00;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_p1 <= '0; m_p2 <= '0; m_deb <= '0; m_hist <= '0;
      m_ie <= '0; m_edg <= '0; m_flag <= '0; m_dout <= '0;
    end else begin
      m_p1   <= pin_in;
      m_p2   <= m_p1;
      m_hist <= m_nw;
      m_deb  <= m_ndeb;
      m_flag <= (m_flag & ~m_clr) | m_set;
      if (bif.wr_en && m_la == 2'd0) m_ie  <= bif.din;
      if (bif.wr_en && m_la == 2'd1) m_edg <= bif.din;
      if (!bif.wr_en && bif.rd_en)
        m_dout <= (m_la == 2'd0) ? m_ie : (m_la == 2'd1) ? m_edg :
                  (m_la == 2'd2) ? m_flag : m_deb;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_dout", bif.dout, m_dout);
    chk("model_irq", {7'd0, irq}, {7'd0, |(m_flag & m_ie)});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bif.addr = a; bif.din = d; bif.wr_en = 1'b1;
    @(negedge clk);
    bif.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    bif.addr = a; bif.rd_en = 1'b1;
    @(negedge clk);
    bif.rd_en = 1'b0;
    chk(nm, bif.dout, exp);
  endtask

  initial begin
    bif.addr = 8'h00; bif.din = 8'h00; bif.wr_en = 1'b0; bif.rd_en = 1'b0;
    tick(2);
    chk("rst_dout", bif.dout, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    reset_n = 1'b1;

    // register access after reset
    for (int a = 0; a < 4; a++) rd(8'(a), 8'h00, "rst_read");
    wr(8'h00, 8'hA5);
    rd(8'h00, 8'hA5, "ie_readback");
    wr(8'h03, 8'hFF);
    rd(8'h03, 8'h00, "level_ro");

    // rising edge on pin 0 lands at edge DB_MAX+3 = 6
    wr(8'h01, 8'h01);
    wr(8'h00, 8'h01);
    pin_in[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) chk("irq_edge5", {7'd0, irq}, 8'h00);
      if (e == 6) chk("irq_edge6", {7'd0, irq}, 8'h01);
    end
    rd(8'h02, 8'h01, "iflag_rise0");
    rd(8'h03, 8'h01, "level_rise0");

    // short pulse rejected, long pulse accepted, falling edge flagged on pin 1
    wr(8'h02, 8'h01);
    pin_in[1] = 1'b1; tick(3); pin_in[1] = 1'b0; tick(8);
    rd(8'h03, 8'h01, "level_pulse3");
    rd(8'h02, 8'h00, "iflag_pulse3");
    pin_in[1] = 1'b1; tick(6);
    rd(8'h03, 8'h03, "level_pulse6");
    pin_in[1] = 1'b0; tick(8);
    rd(8'h02, 8'h02, "iflag_fall1");
    wr(8'h02, 8'h02);

    // falling edge on pin 2 with IE off, then enable, then W1C
    wr(8'h01, 8'h00);
    wr(8'h00, 8'h00);
    pin_in[2] = 1'b1; tick(8);
    pin_in[2] = 1'b0; tick(8);
    rd(8'h02, 8'h04, "iflag_fall2");
    chk("irq_ie_off", {7'd0, irq}, 8'h00);
    wr(8'h00, 8'h04);
    chk("irq_ie_on", {7'd0, irq}, 8'h01);
    wr(8'h02, 8'h04);
    chk("irq_cleared", {7'd0, irq}, 8'h00);
    rd(8'h02, 8'h00, "iflag_cleared");

    // set and W1C of bit 3 on the same edge: set wins
    wr(8'h01, 8'h08);
    wr(8'h00, 8'h08);
    pin_in[3] = 1'b1; tick(5);
    bif.addr = 8'h02; bif.din = 8'h08; bif.wr_en = 1'b1;
    @(negedge clk);
    bif.wr_en = 1'b0;
    chk("irq_set_wins", {7'd0, irq}, 8'h01);
    rd(8'h02, 8'h08, "iflag_set_wins");
    wr(8'h02, 8'h08);
    rd(8'h02, 8'h00, "iflag_w1c3");

    // write has priority over read
    rd(8'h01, 8'h08, "edge_read");
    bif.addr = 8'h00; bif.din = 8'h3C; bif.wr_en = 1'b1; bif.rd_en = 1'b1;
    @(negedge clk);
    bif.wr_en = 1'b0; bif.rd_en = 1'b0;
    chk("wr_rd_dout_hold", bif.dout, 8'h08);
    rd(8'h00, 8'h3C, "wr_rd_ie");

    // reset in the middle of a debounce on pin 4
    wr(8'h01, 8'h10);
    pin_in[4] = 1'b1; tick(3);
    #2 reset_n = 1'b0;
    #1 chk("midrst_dout", bif.dout, 8'h00);
    chk("midrst_irq", {7'd0, irq}, 8'h00);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    rd(8'h03, 8'h00, "level_post_rst5");
    tick(1);
    rd(8'h03, 8'h19, "level_post_rst7");
    rd(8'h02, 8'h00, "iflag_post_rst");
    rd(8'h01, 8'h00, "edge_post_rst");
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
